// File: rtl/larb_sched_pkg.sv
// Shared leaf types and arbiter state encoding for the leaf arbiter/scheduler.
package larb_sched_pkg;

  typedef struct packed {
    logic [15:0] ray_id;
    logic [7:0]  ray_flags;
  } ray_info_t;

  typedef struct packed {
    logic [7:0]  lnum_left;
    logic [23:0] lindex;
  } ln_tri_t;

  typedef struct packed {
    ray_info_t ray_info;
    ln_tri_t   ln_tri;
  } leaf_info_t;

  typedef enum logic {
    LOOP_PRI  = 1'b0,
    TRAV_TURN = 1'b1
  } larb_state_e;

  localparam int LEAF_W = $bits(leaf_info_t);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/larb_skid_buf.sv
// Two-entry skid FIFO between the leaf arbiter and the list cache request port.
module larb_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/larb_sched.sv
// Leaf arbiter: loopback-priority merge of traversal and intersection leaves with a burst limit.
// Optional statistics counters are enabled by defining LARB_STATS_EN.
module larb_sched
  import larb_sched_pkg::*;
#(
  parameter int MAX_LOOP_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trav_to_larb_valid,
  input  leaf_info_t  trav_to_larb_data,
  output logic        trav_to_larb_stall,
  input  logic        int_to_larb_valid,
  input  leaf_info_t  int_to_larb_data,
  output logic        int_to_larb_stall,
  output logic        larb_to_lcache_valid,
  output leaf_info_t  larb_to_lcache_data,
  input  logic        larb_to_lcache_stall,
  output logic [31:0] stat_loop_grants,
  output logic [31:0] stat_trav_grants,
  output logic [31:0] stat_ds_stall_cyc
);

  localparam logic [7:0] MAX_B = 8'(MAX_LOOP_BURST);

  larb_state_e state_q, state_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [1:0]  count;
  leaf_info_t  head;
  logic        can_acc, grant_int, grant_trav, push, pop;
  leaf_info_t  push_data;

  // Acceptance depends only on registered occupancy, keeping the downstream stall off the input stalls.
  assign can_acc = (count < 2'd2);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    grant_int   = 1'b0;
    grant_trav  = 1'b0;
    if (!rst) begin
      case (state_q)
        LOOP_PRI: begin
          if (can_acc && int_to_larb_valid) begin
            grant_int = 1'b1;
            if (trav_to_larb_valid) begin
              burst_cnt_d = burst_cnt_q + 8'd1;
              if (burst_cnt_q + 8'd1 == MAX_B) state_d = TRAV_TURN;
            end else begin
              burst_cnt_d = 8'd0;
            end
          end else if (can_acc && trav_to_larb_valid) begin
            grant_trav  = 1'b1;
            burst_cnt_d = 8'd0;
          end else if (!trav_to_larb_valid) begin
            burst_cnt_d = 8'd0;
          end
        end
        TRAV_TURN: begin
          if (!trav_to_larb_valid) begin
            state_d     = LOOP_PRI;
            burst_cnt_d = 8'd0;
            grant_int   = can_acc & int_to_larb_valid;
          end else if (can_acc) begin
            grant_trav  = 1'b1;
            burst_cnt_d = 8'd0;
            state_d     = LOOP_PRI;
          end
        end
        default: state_d = LOOP_PRI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOOP_PRI;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign push      = grant_int | grant_trav;
  assign push_data = grant_int ? int_to_larb_data : trav_to_larb_data;
  assign pop       = larb_to_lcache_valid & ~larb_to_lcache_stall;

  larb_skid_buf #(.WIDTH(LEAF_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign trav_to_larb_stall   = ~grant_trav;
  assign int_to_larb_stall    = ~grant_int;
  assign larb_to_lcache_valid = (count != 2'd0) & ~rst;
  assign larb_to_lcache_data  = head;

`ifdef LARB_STATS_EN
  logic [31:0] loop_cnt_q, loop_cnt_d;
  logic [31:0] trav_cnt_q, trav_cnt_d;
  logic [31:0] ds_cnt_q, ds_cnt_d;

  always_comb begin
    loop_cnt_d = sat_inc(loop_cnt_q, grant_int);
    trav_cnt_d = sat_inc(trav_cnt_q, grant_trav);
    ds_cnt_d   = sat_inc(ds_cnt_q, larb_to_lcache_valid & larb_to_lcache_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loop_cnt_q <= 32'd0;
      trav_cnt_q <= 32'd0;
      ds_cnt_q   <= 32'd0;
    end else begin
      loop_cnt_q <= loop_cnt_d;
      trav_cnt_q <= trav_cnt_d;
      ds_cnt_q   <= ds_cnt_d;
    end
  end

  assign stat_loop_grants  = loop_cnt_q;
  assign stat_trav_grants  = trav_cnt_q;
  assign stat_ds_stall_cyc = ds_cnt_q;
`else
  assign stat_loop_grants  = 32'd0;
  assign stat_trav_grants  = 32'd0;
  assign stat_ds_stall_cyc = 32'd0;
`endif

  // Empty leaves never reach this block; traversal filters them.
  always_ff @(posedge clk) begin
    if (!rst && trav_to_larb_valid)
      assert (trav_to_larb_data.ln_tri.lnum_left != 8'd0)
        else $error("larb_sched: traversal leaf with lnum_left == 0");
  end

endmodule

// File: tb/tb_larb_sched.sv
// Randomized and directed bench for larb_sched against a queue-based arbitration model.
module tb_larb_sched;
  import larb_sched_pkg::*;

  localparam int MAXB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        tv, iv, ls;
  leaf_info_t  td, id;
  logic        trav_stall, int_stall, out_valid;
  leaf_info_t  out_data;
  logic [31:0] s_loop, s_trav, s_ds;

  larb_sched #(.MAX_LOOP_BURST(MAXB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .trav_to_larb_valid   (tv),
    .trav_to_larb_data    (td),
    .trav_to_larb_stall   (trav_stall),
    .int_to_larb_valid    (iv),
    .int_to_larb_data     (id),
    .int_to_larb_stall    (int_stall),
    .larb_to_lcache_valid (out_valid),
    .larb_to_lcache_data  (out_data),
    .larb_to_lcache_stall (ls),
    .stat_loop_grants     (s_loop),
    .stat_trav_grants     (s_trav),
    .stat_ds_stall_cyc    (s_ds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  leaf_info_t  mq[$];
  leaf_info_t  popped[$];
  int          run;
  logic [31:0] m_loop, m_trav, m_ds;
  logic        obs_gi, obs_gt, obs_v;
  int          n_push;
  int          tag = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic leaf_info_t mk();
    leaf_info_t l;
    l.ray_info.ray_id    = 16'(tag);
    l.ray_info.ray_flags = 8'($urandom);
    l.ln_tri.lnum_left   = 8'($urandom_range(1, 255));
    l.ln_tri.lindex      = 24'($urandom);
    tag++;
    return l;
  endfunction

  task automatic check_stats();
`ifdef LARB_STATS_EN
    chk("stat_loop", 64'(s_loop), 64'(m_loop));
    chk("stat_trav", 64'(s_trav), 64'(m_trav));
    chk("stat_ds", 64'(s_ds), 64'(m_ds));
`else
    chk("stat_loop_off", 64'(s_loop), 64'd0);
    chk("stat_trav_off", 64'(s_trav), 64'd0);
    chk("stat_ds_off", 64'(s_ds), 64'd0);
`endif
  endtask

  // Model: loopback wins unless MAXB loopback grants happened in a row while trav waited.
  task automatic model_cycle();
    logic can, turn, gt, gi, ev;
    obs_gi = ~int_stall;
    obs_gt = ~trav_stall;
    obs_v  = out_valid;
    check_stats();
    if (rst) begin
      chk("rst_trav_stall", 64'(trav_stall), 64'd1);
      chk("rst_int_stall", 64'(int_stall), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      mq.delete();
      run = 0;
      m_loop = 0; m_trav = 0; m_ds = 0;
      return;
    end
    can  = (mq.size() < 2);
    turn = (run >= MAXB);
    gt   = can && tv && (!iv || turn);
    gi   = can && iv && !gt;
    ev   = (mq.size() != 0);
    chk("trav_stall", 64'(trav_stall), 64'(!gt));
    chk("int_stall", 64'(int_stall), 64'(!gi));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) chk("out_data", 64'(out_data), 64'(mq[0]));
    if (ev && !ls) begin
      popped.push_back(out_data);
      void'(mq.pop_front());
    end
    if (gt) mq.push_back(td);
    else if (gi) mq.push_back(id);
    if (gt || gi) n_push++;
    if (gt) m_trav++;
    if (gi) m_loop++;
    if (ev && ls) m_ds++;
    if (!tv || gt) run = 0;
    else if (gi) run++;
  endtask

  task automatic tick();
    #1;
    model_cycle();
    @(negedge clk);
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) tick();
    rst = 1'b0;
  endtask

  initial begin
    string seq;
    int    gcnt;
    rst = 1'b1; tv = 1'b0; iv = 1'b0; ls = 1'b0;
    td = mk(); id = mk();
    run = 0; m_loop = 0; m_trav = 0; m_ds = 0; n_push = 0;
    @(negedge clk);
    reset_cycles(2);

    // Trav only: four leaves, one per cycle, order kept.
    popped.delete();
    for (int k = 0; k < 4; k++) begin
      tv = 1'b1; td = mk(); td.ray_info.ray_id = 16'h100 + 16'(k);
      tick();
      chk("t1_granted", 64'(obs_gt), 64'd1);
      if (k > 0) chk("t1_latency_valid", 64'(obs_v), 64'd1);
    end
    tv = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t1_count", 64'(popped.size()), 64'd4);
    for (int k = 0; k < 4 && k < popped.size(); k++)
      chk("t1_order", 64'(popped[k].ray_info.ray_id), 64'h100 + 64'(k));

    // Both valid continuously: I,I,I,T repeating.
    reset_cycles(1);
    seq = "";
    tv = 1'b1; iv = 1'b1; td = mk(); id = mk();
    for (int k = 0; k < 12; k++) begin
      tick();
      seq = {seq, obs_gi ? "I" : (obs_gt ? "T" : "-")};
      if (obs_gt) td = mk();
      if (obs_gi) id = mk();
    end
    chk("t2_pattern", 64'(seq == "IIITIIITIIIT"), 64'd1);
`ifdef LARB_STATS_EN
    chk("t2_stat_loop", 64'(s_loop), 64'd9);
    chk("t2_stat_trav", 64'(s_trav), 64'd3);
`else
    chk("t2_stat_loop_off", 64'(s_loop), 64'd0);
    chk("t2_stat_trav_off", 64'(s_trav), 64'd0);
`endif

    // Trav drops in TRAV_TURN: int granted the same cycle.
    for (int k = 0; k < 3; k++) begin
      tick();
      if (obs_gi) id = mk();
    end
    tv = 1'b0;
    tick();
    chk("t4_int_granted", 64'(obs_gi), 64'd1);
    chk("t4_trav_not", 64'(obs_gt), 64'd0);
    id = mk(); tv = 1'b1; td = mk();
    tick();
    chk("t4_back_loop_pri", 64'(obs_gi), 64'd1);
    tv = 1'b0; iv = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Downstream stall for 10 cycles: exactly two accepted, then drain.
    reset_cycles(1);
    popped.delete(); n_push = 0; gcnt = 0;
    tv = 1'b1; iv = 1'b1; td = mk(); id = mk(); ls = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      gcnt += int'(obs_gi) + int'(obs_gt);
      if (obs_gt) td = mk();
      if (obs_gi) id = mk();
    end
    chk("t3_accepted", 64'(gcnt), 64'd2);
    chk("t3_stalls_high", 64'({obs_gi, obs_gt}), 64'd0);
    ls = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (obs_gt) td = mk();
      if (obs_gi) id = mk();
    end
    tv = 1'b0; iv = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t3_no_loss", 64'(popped.size()), 64'(n_push));
    chk("t3_drained", 64'(out_valid), 64'd0);

    // Reset with buffer full and burst count at two.
    tv = 1'b1; iv = 1'b1; td = mk(); id = mk(); ls = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (obs_gi) id = mk();
    end
    reset_cycles(1);
    ls = 1'b0;
    seq = "";
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) chk("t5_valid_after_rst", 64'(obs_v), 64'd0);
      seq = {seq, obs_gi ? "I" : (obs_gt ? "T" : "-")};
      if (obs_gt) td = mk();
      if (obs_gi) id = mk();
    end
    chk("t5_burst_cleared", 64'(seq == "IIIT"), 64'd1);

    // Randomized traffic obeying the hold-until-transfer rule.
    for (int k = 0; k < 3000; k++) begin
      if (!(tv && !obs_gt)) begin
        tv = 1'($urandom_range(0, 1));
        td = mk();
      end
      if (!(iv && !obs_gi)) begin
        iv = 1'($urandom_range(0, 1));
        id = mk();
      end
      ls  = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; tv = 1'b0; iv = 1'b0; ls = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
